layer_sequencer: RTL

Time-multiplexed scheduler that evaluates one spiking layer using a single shared multiply-accumulate path instead of one neuron instance per output.
- Accepts an input frame of NUM_INPUTS 8-bit rates over valid/ready.
- Walks every (neuron, input) weight address through an external 1-cycle-latency weight memory.
- Keeps leaky membrane potentials internally and emits a spike vector per timestep.
- Sits between input-layer buffering and the next layer's input register.

---
 rtl/snn_pkg.sv | 12 +
 rtl/snn_mac_update.sv | 38 +++
 rtl/layer_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, potential type, sequencer state enum and potential saturation helper
package snn_pkg;
  localparam int DATA_W = 8;
  localparam int POT_W = 16;
  localparam int POT_MAX = 2 ** (POT_W - 1) - 1;
  localparam int POT_MIN = -(2 ** (POT_W - 1));
  typedef logic signed [POT_W-1:0] pot_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;
  function automatic pot_t sat_pot(input logic signed [31:0] v);
    return v > POT_MAX ? pot_t'(POT_MAX) : v < POT_MIN ? pot_t'(POT_MIN) : pot_t'(v);
  endfunction
endpackage

// File: rtl/snn_mac_update.sv
// snn_mac_update: shared MAC (rate_i*w_i into acc, en_i/last_i framing) plus leak, saturate and threshold of pot_i into pot_o/fire_o
module snn_mac_update
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int THRESHOLD = 1024,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     last_i,
  input  logic [DATA_W-1:0]        rate_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  pot_t                     pot_i,
  output pot_t                     pot_o,
  output logic                     fire_o
);
  localparam int PW = 2 * DATA_W + 1;
  localparam int AW = PW + $clog2(NUM_INPUTS);
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum, acc_q, acc_d;
  logic signed [31:0] tot;
  pot_t leaked, upd;
  always_comb begin
    prod = $signed({{(DATA_W + 1){1'b0}}, rate_i}) * $signed({{(DATA_W + 1){w_i[DATA_W-1]}}, w_i});
    sum = acc_q + $signed({{(AW - PW){prod[PW-1]}}, prod});
    leaked = LEAK_SHIFT == 0 ? pot_i : pot_i - (pot_i >>> LEAK_SHIFT);
    tot = $signed({{(32 - AW){sum[AW-1]}}, sum}) + $signed({{(32 - POT_W){leaked[POT_W-1]}}, leaked});
    upd = sat_pot(tot);
    fire_o = $signed({{(32 - POT_W){upd[POT_W-1]}}, upd}) >= THRESHOLD;
    pot_o = fire_o ? '0 : upd;
    acc_d = !en_i ? acc_q : last_i ? '0 : sum;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: time-multiplexed spiking layer; in_* frame handshake, w_rd/w_addr/w_data weight memory, out_* spike handshake, pot_clr clear, busy
module layer_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_NEURONS = 5,
  parameter int THRESHOLD = 1024,
  parameter int LEAK_SHIFT = 4,
  localparam int NI = NUM_NEURONS * NUM_INPUTS,
  localparam int AW = $clog2(NI)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
  input  logic                         pot_clr,
  output logic                         w_rd,
  output logic [AW-1:0]                w_addr,
  input  logic signed [DATA_W-1:0]     w_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_NEURONS-1:0]       out_spikes,
  output logic                         busy
);
  localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  state_t state_q, state_d;
  logic [NUM_INPUTS*DATA_W-1:0] data_q, data_d;
  logic w_rd_q, w_rd_d, v_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] i_q, i_d, id_q;
  logic [NW-1:0] n_q, n_d, nd_q;
  pot_t pot_q [NUM_NEURONS];
  pot_t pot_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] spk_q, spk_d, out_q, out_d;
  logic mac_last, mac_fire;
  pot_t mac_pot;
  assign in_ready = state_q == IDLE && !pot_clr;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == OUT;
  assign w_rd = w_rd_q;
  assign w_addr = addr_q;
  assign out_spikes = out_q;
  assign mac_last = id_q == IW'(NUM_INPUTS - 1);
  snn_mac_update #(
    .NUM_INPUTS(NUM_INPUTS),
    .THRESHOLD (THRESHOLD),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en_i  (v_q),
    .last_i(mac_last),
    .rate_i(data_q[id_q*DATA_W+:DATA_W]),
    .w_i   (w_data),
    .pot_i (pot_q[nd_q]),
    .pot_o (mac_pot),
    .fire_o(mac_fire)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    w_rd_d = 1'b0;
    addr_d = addr_q;
    i_d = i_q;
    n_d = n_q;
    pot_d = pot_q;
    spk_d = spk_q;
    out_d = out_q;
    unique case (state_q)
      IDLE:
        if (pot_clr) begin
          for (int k = 0; k < NUM_NEURONS; k++) pot_d[k] = '0;
        end else if (in_valid) begin
          state_d = RUN;
          data_d = in_data;
          w_rd_d = 1'b1;
          addr_d = '0;
          i_d = '0;
          n_d = '0;
        end
      RUN:
        if (addr_q == AW'(NI - 1)) state_d = DRAIN;
        else begin
          w_rd_d = 1'b1;
          addr_d = addr_q + AW'(1);
          i_d = i_q == IW'(NUM_INPUTS - 1) ? '0 : i_q + IW'(1);
          n_d = i_q == IW'(NUM_INPUTS - 1) ? n_q + NW'(1) : n_q;
        end
      DRAIN:
        if (!v_q) begin
          state_d = OUT;
          out_d = spk_q;
        end
      OUT: state_d = out_ready ? IDLE : OUT;
    endcase
    if (v_q && mac_last) begin
      pot_d[nd_q] = mac_pot;
      spk_d[nd_q] = mac_fire;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      w_rd_q <= 1'b0;
      addr_q <= '0;
      i_q <= '0;
      n_q <= '0;
      v_q <= 1'b0;
      id_q <= '0;
      nd_q <= '0;
      pot_q <= '{default: '0};
      spk_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      w_rd_q <= w_rd_d;
      addr_q <= addr_d;
      i_q <= i_d;
      n_q <= n_d;
      v_q <= w_rd_q;
      id_q <= i_q;
      nd_q <= n_q;
      pot_q <= pot_d;
      spk_q <= spk_d;
      out_q <= out_d;
    end
endmodule
